// File: rtl/wb_ctrl_pipe_if.sv
// Decode-to-writeback control bus: decode-side inputs, writeback outputs and
// per-stage pending-write information for the hazard unit.
interface wb_ctrl_pipe_if #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned OPC_W  = 6
);
    logic                       in_valid;
    logic [OPC_W-1:0]           opcode;
    logic [REG_AW-1:0]          dest;
    logic [REG_AW-1:0]          src_a;
    logic [REG_AW-1:0]          src_b;
    logic                       stall;
    logic                       flush;
    logic                       wb_valid;
    logic                       wb_mem_to_reg;
    logic                       wb_reg_write;
    logic [REG_AW-1:0]          wb_dest;
    logic [STAGES-1:0]          stage_reg_write;
    logic [STAGES*REG_AW-1:0]   stage_dest;
    logic                       load_use_hazard;
    logic                       illegal_op;

    modport master (
        output in_valid, opcode, dest, src_a, src_b, stall, flush,
        input  wb_valid, wb_mem_to_reg, wb_reg_write, wb_dest,
               stage_reg_write, stage_dest, load_use_hazard, illegal_op
    );

    modport slave (
        input  in_valid, opcode, dest, src_a, src_b, stall, flush,
        output wb_valid, wb_mem_to_reg, wb_reg_write, wb_dest,
               stage_reg_write, stage_dest, load_use_hazard, illegal_op
    );
endinterface

// File: rtl/wb_ctrl_pipe.sv
// Writeback-control decoder plus a STAGES-deep control pipeline with stall,
// flush and bubble handling, pending-write export and load-use detection.
module wb_ctrl_pipe #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned OPC_W  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_ctrl_pipe_if.slave bus
);
    localparam int unsigned LAST = STAGES - 1;

    typedef struct packed {
        logic              valid;
        logic              memToReg;
        logic              regWrite;
        logic [REG_AW-1:0] dest;
    } stageT;

    stageT                    pipe [STAGES];
    stageT                    entry;
    logic                     decMemToReg;
    logic                     decRegWrite;
    logic                     decKnown;
    logic                     illegalOp;
    logic [STAGES-1:0]        stageRegWrite;
    logic [STAGES*REG_AW-1:0] stageDest;

    // Opcode decode into {mem_to_reg, reg_write}
    always_comb begin
        decMemToReg = 1'b0;
        decRegWrite = 1'b0;
        decKnown    = 1'b1;
        case (bus.opcode)
            OPC_W'(6'b000000), OPC_W'(6'b001000), OPC_W'(6'b001101),
            OPC_W'(6'b001100), OPC_W'(6'b001010): decRegWrite = 1'b1;
            OPC_W'(6'b100011): begin
                decMemToReg = 1'b1;
                decRegWrite = 1'b1;
            end
            OPC_W'(6'b101011), OPC_W'(6'b000100), OPC_W'(6'b000101),
            OPC_W'(6'b000010): decRegWrite = 1'b0;
            default:           decKnown    = 1'b0;
        endcase
    end

    // Entry presented to stage 0; a squashed or absent instruction is a full bubble
    always_comb begin
        entry = '0;
        if (bus.in_valid && !bus.flush) begin
            entry.valid    = 1'b1;
            entry.memToReg = decMemToReg;
            entry.regWrite = decRegWrite && (bus.dest != '0);
            entry.dest     = bus.dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                pipe[i] <= '0;
            end
            illegalOp <= 1'b0;
        end else begin
            if (!bus.stall) begin
                pipe[0] <= entry;
                for (int i = 1; i < int'(STAGES); i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end else if (bus.flush) begin
                pipe[0] <= '0;
            end
            illegalOp <= bus.in_valid && !bus.flush && !bus.stall && !decKnown;
        end
    end

    always_comb begin
        stageRegWrite = '0;
        stageDest     = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            stageRegWrite[i]              = pipe[i].valid & pipe[i].regWrite;
            stageDest[i*REG_AW +: REG_AW] = pipe[i].dest;
        end
    end

    assign bus.wb_valid        = pipe[LAST].valid;
    assign bus.wb_mem_to_reg   = pipe[LAST].memToReg;
    assign bus.wb_reg_write    = pipe[LAST].valid & pipe[LAST].regWrite;
    assign bus.wb_dest         = pipe[LAST].dest;
    assign bus.stage_reg_write = stageRegWrite;
    assign bus.stage_dest      = stageDest;
    assign bus.illegal_op      = illegalOp;

    // Load in stage 0 feeding the instruction now in decode
    assign bus.load_use_hazard = bus.in_valid & pipe[0].valid & pipe[0].memToReg
                               & pipe[0].regWrite
                               & ((pipe[0].dest == bus.src_a) | (pipe[0].dest == bus.src_b));
endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Directed bench for wb_ctrl_pipe: default depth plus STAGES=1 and STAGES=5
// instances driven from the same decode-side stimulus.
module tb_wb_ctrl_pipe;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inValid, stall, flush;
    logic [5:0] opcode;
    logic [4:0] dest, srcA, srcB;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    wb_ctrl_pipe_if #(.STAGES(3)) bus3 ();
    wb_ctrl_pipe_if #(.STAGES(1)) bus1 ();
    wb_ctrl_pipe_if #(.STAGES(5)) bus5 ();

    assign bus3.in_valid = inValid; assign bus3.opcode = opcode; assign bus3.dest = dest;
    assign bus3.src_a = srcA; assign bus3.src_b = srcB; assign bus3.stall = stall; assign bus3.flush = flush;
    assign bus1.in_valid = inValid; assign bus1.opcode = opcode; assign bus1.dest = dest;
    assign bus1.src_a = srcA; assign bus1.src_b = srcB; assign bus1.stall = stall; assign bus1.flush = flush;
    assign bus5.in_valid = inValid; assign bus5.opcode = opcode; assign bus5.dest = dest;
    assign bus5.src_a = srcA; assign bus5.src_b = srcB; assign bus5.stall = stall; assign bus5.flush = flush;

    wb_ctrl_pipe #(.STAGES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    wb_ctrl_pipe #(.STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    wb_ctrl_pipe #(.STAGES(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] d);
        inValid = v;
        opcode  = op;
        dest    = d;
    endtask

    task automatic drain();
        drive(1'b0, 6'd0, 5'd0);
        stall = 1'b0;
        flush = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        logic [2:0] expSrw;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; srcA = 5'd8; srcB = 5'd8;
        drive(1'b1, OP_LW, 5'd8);
        repeat (2) tick();
        total++; if ({bus3.wb_valid, bus3.wb_mem_to_reg, bus3.wb_reg_write, bus3.wb_dest} !== 8'd0) begin bad++; $display("FAIL reset_wb3 got=%b exp=0", {bus3.wb_valid, bus3.wb_mem_to_reg, bus3.wb_reg_write, bus3.wb_dest}); end
        total++; if ({bus3.stage_reg_write, bus3.stage_dest} !== 18'd0) begin bad++; $display("FAIL reset_stage3 got=%h exp=0", {bus3.stage_reg_write, bus3.stage_dest}); end
        total++; if ({bus3.illegal_op, bus3.load_use_hazard, bus1.wb_valid, bus5.wb_valid} !== 4'd0) begin bad++; $display("FAIL reset_misc got=%b exp=0000", {bus3.illegal_op, bus3.load_use_hazard, bus1.wb_valid, bus5.wb_valid}); end
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) inValid = 1'b0;
            expSrw = (k <= 3) ? 3'(1 << (k - 1)) : 3'd0;
            total++; if (bus3.stage_reg_write !== expSrw) begin bad++; $display("FAIL lat3_srw k=%0d got=%b exp=%b", k, bus3.stage_reg_write, expSrw); end
            total++; if (bus3.wb_valid !== (k == 3)) begin bad++; $display("FAIL lat3_valid k=%0d got=%b exp=%b", k, bus3.wb_valid, k == 3); end
            total++; if (bus1.wb_valid !== (k == 1)) begin bad++; $display("FAIL lat1_valid k=%0d got=%b exp=%b", k, bus1.wb_valid, k == 1); end
            total++; if (bus5.wb_valid !== (k == 5)) begin bad++; $display("FAIL lat5_valid k=%0d got=%b exp=%b", k, bus5.wb_valid, k == 5); end
            if (k == 3) begin
                total++; if ({bus3.wb_mem_to_reg, bus3.wb_reg_write, bus3.wb_dest} !== {2'b11, 5'd8}) begin bad++; $display("FAIL lat3_ctrl got=%b exp=1101000", {bus3.wb_mem_to_reg, bus3.wb_reg_write, bus3.wb_dest}); end
            end
            if (k == 1) begin
                total++; if ({bus1.wb_mem_to_reg, bus1.wb_reg_write, bus1.wb_dest, bus1.stage_dest} !== {2'b11, 5'd8, 5'd8}) begin bad++; $display("FAIL lat1_ctrl got=%h", {bus1.wb_mem_to_reg, bus1.wb_reg_write, bus1.wb_dest, bus1.stage_dest}); end
            end
            if (k == 5) begin
                total++; if ({bus5.wb_mem_to_reg, bus5.wb_reg_write, bus5.wb_dest} !== {2'b11, 5'd8}) begin bad++; $display("FAIL lat5_ctrl got=%b exp=1101000", {bus5.wb_mem_to_reg, bus5.wb_reg_write, bus5.wb_dest}); end
            end
        end
    endtask

    task automatic test_decode();
        logic [5:0] ops [11];
        logic       mr  [11];
        logic       rw  [11];
        logic       ill [11];
        int         j;
        ops = '{OP_R, OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, 6'b000001};
        mr  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        rw  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        ill = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        drain();
        for (int k = 1; k <= 13; k++) begin
            if (k <= 11) drive(1'b1, ops[k-1], 5'(k + 10)); else drive(1'b0, 6'd0, 5'd0);
            tick();
            if (k <= 11) begin
                total++; if (bus3.illegal_op !== ill[k-1]) begin bad++; $display("FAIL dec_illegal op=%b got=%b exp=%b", ops[k-1], bus3.illegal_op, ill[k-1]); end
            end
            j = k - 3;
            if (j >= 0 && j < 11) begin
                total++; if ({bus3.wb_valid, bus3.wb_mem_to_reg, bus3.wb_reg_write} !== {1'b1, mr[j], rw[j]}) begin bad++; $display("FAIL dec_wb op=%b got=%b exp=%b", ops[j], {bus3.wb_valid, bus3.wb_mem_to_reg, bus3.wb_reg_write}, {1'b1, mr[j], rw[j]}); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [4];
        logic [4:0] ds  [4];
        logic       mr  [4];
        logic       rw  [4];
        logic [2:0] expSrw;
        int         j;
        ops = '{OP_ADDI, OP_LW, OP_SW, OP_BEQ};
        ds  = '{5'd3, 5'd4, 5'd9, 5'd0};
        mr  = '{0, 1, 0, 0};
        rw  = '{1, 1, 0, 0};
        drain();
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) drive(1'b1, ops[k-1], ds[k-1]); else drive(1'b0, 6'd0, 5'd0);
            tick();
            expSrw = '0;
            for (int i = 0; i < 3; i++) begin
                j = k - 1 - i;
                if (j >= 0 && j < 4) expSrw[i] = rw[j];
            end
            total++; if (bus3.stage_reg_write !== expSrw) begin bad++; $display("FAIL b2b_srw k=%0d got=%b exp=%b", k, bus3.stage_reg_write, expSrw); end
            j = k - 3;
            if (j >= 0) begin
                total++; if ({bus3.wb_valid, bus3.wb_mem_to_reg, bus3.wb_reg_write} !== {1'b1, mr[j], rw[j]}) begin bad++; $display("FAIL b2b_wb k=%0d got=%b exp=%b", k, {bus3.wb_valid, bus3.wb_mem_to_reg, bus3.wb_reg_write}, {1'b1, mr[j], rw[j]}); end
                if (rw[j]) begin
                    total++; if (bus3.wb_dest !== ds[j]) begin bad++; $display("FAIL b2b_dest k=%0d got=%0d exp=%0d", k, bus3.wb_dest, ds[j]); end
                end
            end
        end
    endtask

    task automatic test_zero_dest();
        drain();
        drive(1'b1, OP_ADDI, 5'd0);
        tick();
        drive(1'b0, 6'd0, 5'd0);
        total++; if (bus3.stage_reg_write !== 3'b000) begin bad++; $display("FAIL zero_srw got=%b exp=000", bus3.stage_reg_write); end
        repeat (2) tick();
        total++; if ({bus3.wb_valid, bus3.wb_reg_write} !== 2'b10) begin bad++; $display("FAIL zero_wb got=%b exp=10", {bus3.wb_valid, bus3.wb_reg_write}); end
    endtask

    task automatic test_load_use();
        drain();
        drive(1'b1, OP_LW, 5'd5);
        tick();
        drive(1'b1, OP_ADDI, 5'd9); srcA = 5'd1; srcB = 5'd5; #1;
        total++; if (bus3.load_use_hazard !== 1'b1) begin bad++; $display("FAIL lu_srcb got=%b exp=1", bus3.load_use_hazard); end
        srcA = 5'd5; srcB = 5'd6; #1;
        total++; if (bus3.load_use_hazard !== 1'b1) begin bad++; $display("FAIL lu_srca got=%b exp=1", bus3.load_use_hazard); end
        srcA = 5'd6; srcB = 5'd6; #1;
        total++; if (bus3.load_use_hazard !== 1'b0) begin bad++; $display("FAIL lu_nomatch got=%b exp=0", bus3.load_use_hazard); end
        srcA = 5'd1; srcB = 5'd5; inValid = 1'b0; #1;
        total++; if (bus3.load_use_hazard !== 1'b0) begin bad++; $display("FAIL lu_noinvalid got=%b exp=0", bus3.load_use_hazard); end
        drive(1'b1, OP_ADDI, 5'd5);
        tick();
        #1;
        total++; if (bus3.load_use_hazard !== 1'b0) begin bad++; $display("FAIL lu_addi got=%b exp=0", bus3.load_use_hazard); end
    endtask

    task automatic test_stall();
        drain();
        drive(1'b1, OP_LW, 5'd7);   tick();
        drive(1'b1, OP_ADDI, 5'd2); tick();
        stall = 1'b1;
        drive(1'b1, OP_ADDI, 5'd9);
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if ({bus3.stage_reg_write, bus3.stage_dest[9:0], bus3.wb_valid} !== {3'b011, 5'd7, 5'd2, 1'b0}) begin bad++; $display("FAIL stall_hold k=%0d got=%b", k, {bus3.stage_reg_write, bus3.stage_dest[9:0], bus3.wb_valid}); end
        end
        stall = 1'b0;
        drive(1'b0, 6'd0, 5'd0);
        tick();
        total++; if ({bus3.wb_valid, bus3.wb_mem_to_reg, bus3.wb_dest, bus3.stage_reg_write} !== {2'b11, 5'd7, 3'b110}) begin bad++; $display("FAIL stall_release got=%b", {bus3.wb_valid, bus3.wb_mem_to_reg, bus3.wb_dest, bus3.stage_reg_write}); end

        drain();
        drive(1'b1, OP_LW, 5'd7);   tick();
        drive(1'b1, OP_ADDI, 5'd2); tick();
        stall = 1'b1; flush = 1'b1;
        drive(1'b1, OP_ADDI, 5'd9);
        tick();
        total++; if ({bus3.stage_reg_write, bus3.stage_dest[9:0], bus3.wb_valid} !== {3'b010, 5'd7, 5'd0, 1'b0}) begin bad++; $display("FAIL stall_flush got=%b", {bus3.stage_reg_write, bus3.stage_dest[9:0], bus3.wb_valid}); end
        stall = 1'b0;
        drive(1'b1, OP_ADDI, 5'd3);
        tick();
        flush = 1'b0;
        total++; if ({bus3.stage_reg_write, bus3.wb_valid, bus3.wb_mem_to_reg, bus3.wb_dest} !== {3'b100, 2'b11, 5'd7}) begin bad++; $display("FAIL flush_adv got=%b", {bus3.stage_reg_write, bus3.wb_valid, bus3.wb_mem_to_reg, bus3.wb_dest}); end
    endtask

    task automatic test_illegal();
        drain();
        drive(1'b1, OP_BAD, 5'd6);
        tick();
        total++; if ({bus3.illegal_op, bus3.stage_reg_write} !== 4'b1000) begin bad++; $display("FAIL ill_pulse got=%b exp=1000", {bus3.illegal_op, bus3.stage_reg_write}); end
        drive(1'b0, 6'd0, 5'd0);
        tick();
        total++; if (bus3.illegal_op !== 1'b0) begin bad++; $display("FAIL ill_width got=%b exp=0", bus3.illegal_op); end
        tick();
        total++; if ({bus3.wb_valid, bus3.wb_reg_write} !== 2'b10) begin bad++; $display("FAIL ill_wb got=%b exp=10", {bus3.wb_valid, bus3.wb_reg_write}); end
        drive(1'b1, OP_BAD, 5'd6); flush = 1'b1;
        tick();
        total++; if (bus3.illegal_op !== 1'b0) begin bad++; $display("FAIL ill_flush got=%b exp=0", bus3.illegal_op); end
        flush = 1'b0; stall = 1'b1;
        tick();
        total++; if (bus3.illegal_op !== 1'b0) begin bad++; $display("FAIL ill_stall got=%b exp=0", bus3.illegal_op); end
        stall = 1'b0;
        drive(1'b0, 6'd0, 5'd0);
    endtask

    task automatic test_reset_midflight();
        drain();
        drive(1'b1, OP_LW, 5'd12); tick();
        drive(1'b1, OP_BAD, 5'd13); tick();
        #2 rst_n = 1'b0; #1;
        total++; if ({bus3.stage_reg_write, bus3.wb_valid, bus3.illegal_op, bus5.stage_reg_write} !== 10'd0) begin bad++; $display("FAIL rst_mid got=%b exp=0", {bus3.stage_reg_write, bus3.wb_valid, bus3.illegal_op, bus5.stage_reg_write}); end
        drive(1'b0, 6'd0, 5'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        total++; if ({bus3.wb_valid, bus3.wb_reg_write, bus5.stage_reg_write} !== 7'd0) begin bad++; $display("FAIL rst_nowrite got=%b exp=0", {bus3.wb_valid, bus3.wb_reg_write, bus5.stage_reg_write}); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_zero_dest();
        test_load_use();
        test_stall();
        test_illegal();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
